// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX between a 16-bit (two-byte) port A and an 8-bit port B.
// Sequences each byte on tx_busy, flags lost frames and drives the TX clock-gate enable.
module uart_tx_arbiter #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned BUSY_TIMEOUT = 7
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                a_valid,
  input  logic [2*DATA_W-1:0] a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_ready,
  input  logic                tx_busy,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_data_valid,
  output logic                tx_err,
  output logic                clk_gate_en
);

  localparam int unsigned HOLD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t              state, state_d;
  logic [HOLD_W-1:0]   hold, hold_d;
  logic                byte_sel, byte_sel_d;
  logic                is_a, is_a_d;
  logic                last_b, last_b_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                grant_a;
  logic                a_ready_d, b_ready_d, tx_data_valid_d, tx_err_d, clk_gate_en_d;
  logic [DATA_W-1:0]   tx_data_d;

  // State, hold and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      hold          <= '0;
      byte_sel      <= 1'b0;
      is_a          <= 1'b0;
      last_b        <= 1'b1;
      cnt           <= '0;
      a_ready       <= 1'b0;
      b_ready       <= 1'b0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      tx_err        <= 1'b0;
      clk_gate_en   <= 1'b0;
    end else begin
      state         <= state_d;
      hold          <= hold_d;
      byte_sel      <= byte_sel_d;
      is_a          <= is_a_d;
      last_b        <= last_b_d;
      cnt           <= cnt_d;
      a_ready       <= a_ready_d;
      b_ready       <= b_ready_d;
      tx_data       <= tx_data_d;
      tx_data_valid <= tx_data_valid_d;
      tx_err        <= tx_err_d;
      clk_gate_en   <= clk_gate_en_d;
    end
  end

  // Next-state and next-output logic; outputs are computed from the next state
  always_comb begin
    state_d    = state;
    hold_d     = hold;
    byte_sel_d = byte_sel;
    is_a_d     = is_a;
    last_b_d   = last_b;
    cnt_d      = cnt;
    a_ready_d  = 1'b0;
    b_ready_d  = 1'b0;
    tx_err_d   = 1'b0;
    grant_a    = a_valid && (!b_valid || last_b);

    case (state)
      IDLE: begin
        if (!tx_busy && (a_valid || b_valid)) begin
          state_d    = SEND;
          byte_sel_d = 1'b0;
          is_a_d     = grant_a;
          last_b_d   = !grant_a;
          if (grant_a) begin
            hold_d    = a_data;
            a_ready_d = 1'b1;
          end else begin
            hold_d    = {{DATA_W{1'b0}}, b_data};
            b_ready_d = 1'b1;
          end
        end
      end
      SEND: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else begin
          cnt_d = cnt + CNT_W'(1);
          if (cnt_d == CNT_W'(BUSY_TIMEOUT)) begin
            tx_err_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      WAIT_LO: begin
        // Only port A has a second byte to send
        if (!tx_busy) begin
          if (is_a && !byte_sel) begin
            byte_sel_d = 1'b1;
            state_d    = SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_data_valid_d = (state_d == SEND);
    tx_data_d       = tx_data;
    if (state_d == SEND) begin
      tx_data_d = byte_sel_d ? hold_d[HOLD_W-1:DATA_W] : hold_d[DATA_W-1:0];
    end
    clk_gate_en_d = (state != IDLE) || a_valid || b_valid || tx_busy;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART busy model
// (busy rises 2 cycles after a valid pulse and stays high 10 cycles).
module tb_uart_tx_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        a_valid = 1'b0;
  logic [15:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [7:0]  b_data = '0;
  logic        b_ready;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_err;
  logic        clk_gate_en;

  int checks = 0;
  int errors = 0;

  logic mbusy = 1'b0;
  logic force_busy = 1'b0;
  logic model_en = 1'b1;
  int   dly = 0;
  int   len = 0;

  int a_rdy_cnt = 0;
  int b_rdy_cnt = 0;
  int vld_cnt = 0;
  int vld_busy = 0;
  int err_cnt = 0;
  logic [7:0] bytes[$];
  bit grants[$];

  assign tx_busy = mbusy | force_busy;

  uart_tx_arbiter #(.DATA_W(8), .BUSY_TIMEOUT(7)) dut (
    .CLK(CLK), .RST(RST),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_err(tx_err), .clk_gate_en(clk_gate_en)
  );

  always #5 CLK = ~CLK;

  // UART busy model
  always @(posedge CLK) begin
    if (len > 0) begin
      len <= len - 1;
      if (len == 1) mbusy <= 1'b0;
    end
    if (dly > 0) begin
      dly <= dly - 1;
      if (dly == 1) begin
        mbusy <= 1'b1;
        len   <= 10;
      end
    end
    if (tx_data_valid && model_en) dly <= 1;
  end

  // Transaction monitor
  always @(posedge CLK) begin
    if (RST) begin
      if (a_ready) begin a_rdy_cnt++; grants.push_back(1'b1); end
      if (b_ready) begin b_rdy_cnt++; grants.push_back(1'b0); end
      if (tx_data_valid) begin
        vld_cnt++;
        bytes.push_back(tx_data);
        if (tx_busy) vld_busy++;
      end
      if (tx_err) err_cnt++;
    end
  end

  task automatic wait_ready(input bit port_a, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLK);
      if (port_a ? a_ready : b_ready) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b expected 0", a_ready); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready: got %b expected 0", b_ready); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_data_valid); end
    checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL reset_tx_err: got %b expected 0", tx_err); end
    checks++; if (clk_gate_en !== 1'b0) begin errors++; $display("FAIL reset_gate: got %b expected 0", clk_gate_en); end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_single_b();
    int v0, r0, q0;
    bit seen;
    v0 = vld_cnt; r0 = b_rdy_cnt; q0 = bytes.size();
    b_valid = 1'b1; b_data = 8'h5A;
    wait_ready(1'b0, 20, seen);
    b_valid = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL single_b_ready: got no ready expected pulse"); end
    checks++; if (tx_data_valid !== 1'b1) begin errors++; $display("FAIL single_b_valid: got %b expected 1", tx_data_valid); end
    checks++; if (tx_data !== 8'h5A) begin errors++; $display("FAIL single_b_data: got %h expected 5a", tx_data); end
    @(negedge CLK);
    checks++; if (b_ready !== 1'b0 || tx_data_valid !== 1'b0) begin errors++; $display("FAIL single_b_pulse_width: got ready=%b valid=%b expected 0 0", b_ready, tx_data_valid); end
    repeat (20) @(negedge CLK);
    checks++; if (vld_cnt - v0 != 1) begin errors++; $display("FAIL single_b_valid_count: got %0d expected 1", vld_cnt - v0); end
    checks++; if (b_rdy_cnt - r0 != 1) begin errors++; $display("FAIL single_b_ready_count: got %0d expected 1", b_rdy_cnt - r0); end
    checks++; if (bytes.size() <= q0 || bytes[q0] !== 8'h5A) begin errors++; $display("FAIL single_b_byte: got %0d bytes expected 5a logged", bytes.size() - q0); end
    checks++; if (clk_gate_en !== 1'b0) begin errors++; $display("FAIL single_b_idle_gate: got %b expected 0", clk_gate_en); end
  endtask

  task automatic test_a_two_bytes();
    int v0, r0, q0, b0, e0;
    bit seen;
    v0 = vld_cnt; r0 = a_rdy_cnt; q0 = bytes.size(); b0 = vld_busy; e0 = err_cnt;
    a_valid = 1'b1; a_data = 16'hBEEF;
    wait_ready(1'b1, 20, seen);
    a_valid = 1'b0; a_data = 16'h0000;
    checks++; if (!seen) begin errors++; $display("FAIL a_ready: got no ready expected pulse"); end
    checks++; if (tx_data !== 8'hEF) begin errors++; $display("FAIL a_lsb_now: got %h expected ef", tx_data); end
    repeat (40) @(negedge CLK);
    checks++; if (a_rdy_cnt - r0 != 1) begin errors++; $display("FAIL a_ready_count: got %0d expected 1", a_rdy_cnt - r0); end
    checks++; if (vld_cnt - v0 != 2) begin errors++; $display("FAIL a_valid_count: got %0d expected 2", vld_cnt - v0); end
    checks++; if (bytes.size() < q0 + 2 || bytes[q0] !== 8'hEF || bytes[q0+1] !== 8'hBE) begin errors++; $display("FAIL a_bytes: got %0d bytes expected ef be", bytes.size() - q0); end
    checks++; if (vld_busy != b0) begin errors++; $display("FAIL a_valid_while_busy: got %0d expected 0", vld_busy - b0); end
    checks++; if (err_cnt != e0) begin errors++; $display("FAIL a_err: got %0d expected 0", err_cnt - e0); end
  endtask

  task automatic test_round_robin();
    int g0, q0;
    bit exp_g[4];
    logic [7:0] exp_b[6];
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_b = '{8'h34, 8'h12, 8'h77, 8'h34, 8'h12, 8'h77};
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    g0 = grants.size(); q0 = bytes.size();
    a_valid = 1'b1; a_data = 16'h1234;
    b_valid = 1'b1; b_data = 8'h77;
    for (int i = 0; i < 400 && grants.size() < g0 + 4; i++) @(negedge CLK);
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (30) @(negedge CLK);
    checks++; if (grants.size() != g0 + 4) begin errors++; $display("FAIL rr_grant_count: got %0d expected 4", grants.size() - g0); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (grants.size() <= g0 + k || grants[g0+k] != exp_g[k]) begin errors++; $display("FAIL rr_grant_%0d: expected port_a=%b", k, exp_g[k]); end
    end
    checks++; if (bytes.size() != q0 + 6) begin errors++; $display("FAIL rr_byte_count: got %0d expected 6", bytes.size() - q0); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (bytes.size() <= q0 + k || bytes[q0+k] !== exp_b[k]) begin errors++; $display("FAIL rr_byte_%0d: expected %h", k, exp_b[k]); end
    end
  endtask

  task automatic test_timeout();
    int v0, e0;
    bit seen;
    v0 = vld_cnt; e0 = err_cnt;
    model_en = 1'b0;
    b_valid = 1'b1; b_data = 8'h33;
    wait_ready(1'b0, 20, seen);
    b_valid = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL to_ready: got no ready expected pulse"); end
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL to_early_%0d: got %b expected 0", k, tx_err); end
    end
    @(negedge CLK);
    checks++; if (tx_err !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", tx_err); end
    @(negedge CLK);
    checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b expected 0", tx_err); end
    repeat (20) @(negedge CLK);
    checks++; if (vld_cnt - v0 != 1) begin errors++; $display("FAIL to_valid_count: got %0d expected 1", vld_cnt - v0); end
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL to_err_count: got %0d expected 1", err_cnt - e0); end
    checks++; if (clk_gate_en !== 1'b0) begin errors++; $display("FAIL to_idle_gate: got %b expected 0", clk_gate_en); end
    model_en = 1'b1;
  endtask

  task automatic test_reset_midframe();
    int v0, q0;
    bit seen;
    v0 = vld_cnt; q0 = bytes.size();
    a_valid = 1'b1; a_data = 16'hABCD;
    wait_ready(1'b1, 20, seen);
    a_valid = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL mid_ready: got no ready expected pulse"); end
    repeat (6) @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data: got %h expected 00", tx_data); end
    checks++; if (clk_gate_en !== 1'b0) begin errors++; $display("FAIL mid_gate: got %b expected 0", clk_gate_en); end
    checks++; if ({a_ready, b_ready, tx_data_valid, tx_err} !== 4'b0000) begin errors++; $display("FAIL mid_pulses: got %b expected 0000", {a_ready, b_ready, tx_data_valid, tx_err}); end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (30) @(negedge CLK);
    checks++; if (vld_cnt - v0 != 1) begin errors++; $display("FAIL mid_no_msb: got %0d valids expected 1", vld_cnt - v0); end
    checks++; if (bytes.size() <= q0 || bytes[q0] !== 8'hCD) begin errors++; $display("FAIL mid_lsb: expected cd"); end
    a_valid = 1'b1;
    wait_ready(1'b1, 20, seen);
    a_valid = 1'b0;
    repeat (40) @(negedge CLK);
    checks++; if (vld_cnt - v0 != 3) begin errors++; $display("FAIL mid_rerequest_count: got %0d expected 3", vld_cnt - v0); end
    checks++; if (bytes.size() < q0 + 3 || bytes[q0+1] !== 8'hCD || bytes[q0+2] !== 8'hAB) begin errors++; $display("FAIL mid_rerequest_bytes: expected cd ab"); end
  endtask

  task automatic test_idle_gate();
    int q0;
    int gate_err;
    q0 = bytes.size();
    gate_err = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      checks++; if (clk_gate_en !== 1'b0) begin errors++; gate_err++; if (gate_err == 1) $display("FAIL idle_gate_%0d: got %b expected 0", k, clk_gate_en); end
    end
    force_busy = 1'b1;
    b_valid = 1'b1; b_data = 8'h66;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      checks++; if (b_ready !== 1'b0 || tx_data_valid !== 1'b0) begin errors++; $display("FAIL busy_hold_%0d: got ready=%b valid=%b expected 0 0", k, b_ready, tx_data_valid); end
    end
    checks++; if (clk_gate_en !== 1'b1) begin errors++; $display("FAIL busy_gate: got %b expected 1", clk_gate_en); end
    force_busy = 1'b0;
    @(negedge CLK);
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL busy_release_grant: got %b expected 1", b_ready); end
    b_valid = 1'b0;
    repeat (20) @(negedge CLK);
    checks++; if (bytes.size() != q0 + 1 || bytes[q0] !== 8'h66) begin errors++; $display("FAIL busy_release_byte: got %0d bytes expected one 66", bytes.size() - q0); end
  endtask

  initial begin
    test_reset();
    test_single_b();
    test_a_two_bytes();
    test_round_robin();
    test_timeout();
    test_reset_midframe();
    test_idle_gate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
